// File: rtl/prog_loader.sv
// Boot-time program loader: turns a framed byte stream into 32-bit
// instruction/data memory writes and holds the CPU in reset until 'G'.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   in_valid/in_data    byte stream input; in_ready accepts a byte
//   mem_we              one-cycle word write strobe
//   mem_sel             0 = instruction memory, 1 = data memory
//   mem_addr            byte address of the word (multiple of 4)
//   mem_wdata           big-endian word (first byte in [31:24])
//   cpu_hold            CPU reset, released after the 'G' command
//   err                 sticky protocol error
//   words_loaded        saturating count of words written since reset
module prog_loader #(
    parameter int MEM_BYTES = 1024,
    parameter int ADDR_W    = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic              mem_sel,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              err,
    output logic [15:0]       words_loaded
);

    typedef enum logic [2:0] {
        IDLE,
        CNT_HI,
        CNT_LO,
        DATA,
        DONE,
        ERROR
    } state_t;

    localparam logic [7:0]  CMD_I     = 8'h49;
    localparam logic [7:0]  CMD_D     = 8'h44;
    localparam logic [7:0]  CMD_G     = 8'h47;
    localparam logic [16:0] MAX_WORDS = 17'(MEM_BYTES / 4);

    state_t              state, state_n;
    logic [15:0]         cnt, cnt_n;
    logic [15:0]         widx, widx_n;
    logic [1:0]          bidx, bidx_n;
    logic [23:0]         shreg, shreg_n;
    logic                we_n;
    logic                sel_n;
    logic [ADDR_W-1:0]   addr_n;
    logic [31:0]         wdata_n;
    logic [15:0]         wl_n;
    logic                acc;

    assign in_ready = (state != DONE) && (state != ERROR);
    assign cpu_hold = (state != DONE);
    assign err      = (state == ERROR);
    assign acc      = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            widx         <= '0;
            bidx         <= '0;
            shreg        <= '0;
            mem_we       <= 1'b0;
            mem_sel      <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            words_loaded <= '0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            widx         <= widx_n;
            bidx         <= bidx_n;
            shreg        <= shreg_n;
            mem_we       <= we_n;
            mem_sel      <= sel_n;
            mem_addr     <= addr_n;
            mem_wdata    <= wdata_n;
            words_loaded <= wl_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        widx_n  = widx;
        bidx_n  = bidx;
        shreg_n = shreg;
        we_n    = 1'b0;
        sel_n   = mem_sel;
        addr_n  = mem_addr;
        wdata_n = mem_wdata;
        wl_n    = words_loaded;

        case (state)
            IDLE: begin
                if (acc) begin
                    if (in_data == CMD_I) begin
                        state_n = CNT_HI;
                        sel_n   = 1'b0;
                    end else if (in_data == CMD_D) begin
                        state_n = CNT_HI;
                        sel_n   = 1'b1;
                    end else if (in_data == CMD_G) begin
                        state_n = DONE;
                    end else begin
                        state_n = ERROR;
                    end
                end
            end
            CNT_HI: begin
                if (acc) begin
                    cnt_n   = {in_data, 8'h00};
                    state_n = CNT_LO;
                end
            end
            CNT_LO: begin
                if (acc) begin
                    cnt_n = {cnt[15:8], in_data};
                    if (cnt_n == 16'd0) begin
                        state_n = IDLE;
                    end else if ({1'b0, cnt_n} > MAX_WORDS) begin
                        state_n = ERROR;
                    end else begin
                        state_n = DATA;
                        widx_n  = '0;
                        bidx_n  = '0;
                    end
                end
            end
            DATA: begin
                if (acc) begin
                    shreg_n = {shreg[15:0], in_data};
                    bidx_n  = bidx + 2'd1;
                    if (bidx == 2'd3) begin
                        we_n    = 1'b1;
                        wdata_n = {shreg, in_data};
                        addr_n  = ADDR_W'({widx, 2'b00});
                        widx_n  = widx + 16'd1;
                        if (words_loaded != 16'hFFFF)
                            wl_n = words_loaded + 16'd1;
                        // Last word of the frame: back to IDLE on its 4th byte.
                        if (widx == cnt - 16'd1)
                            state_n = IDLE;
                    end
                end
            end
            DONE:    ;
            ERROR:   ;
            default: state_n = ERROR;
        endcase
    end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Boot-time program loader sitting directly upstream of the MIPS core.
- Accepts a framed byte stream and writes 32-bit words into instruction memory or data memory.
- Holds the CPU in reset until a "go" command arrives.
- Replaces file-based memory preload, so the core can be started from an external host/bench byte source.

Parameters:
- MEM_BYTES, 1024, byte capacity of each target memory; must be a multiple of 4.
- ADDR_W, 10, width of mem_addr; must satisfy 2**ADDR_W >= MEM_BYTES.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  byte-stream valid.
- in_data  in  8  byte-stream data.
- in_ready  out  1  loader accepts byte; a transfer occurs at a rising edge with in_valid && in_ready.
- mem_we  out  1  single-cycle word write strobe.
- mem_sel  out  1  0 = instruction memory, 1 = data memory.
- mem_addr  out  ADDR_W  byte address of word (always a multiple of 4).
- mem_wdata  out  32  word, big-endian: first byte received in [31:24].
- cpu_hold  out  1  drives CPU reset; high while loading.
- err  out  1  sticky protocol error.
- words_loaded  out  16  total words written since reset, across all frames.

Behaviour:
- Reset (synchronous, active-high): state IDLE; in_ready=1, mem_we=0, mem_sel=0, mem_addr=0, mem_wdata=0, cpu_hold=1, err=0, words_loaded=0. Asserting reset mid-frame aborts the frame with no partial write.
- Frame format: command byte, then for load commands count_hi, count_lo, then count words of 4 bytes each.
  - Commands: 0x49 'I' loads IM; 0x44 'D' loads DM; 0x47 'G' starts the CPU.
- States: IDLE, CNT_HI, CNT_LO, DATA, DONE, ERROR.
- IDLE, on accepted byte:
  - 'I' -> CNT_HI, mem_sel=0.
  - 'D' -> CNT_HI, mem_sel=1.
  - 'G' -> DONE.
  - Any other value -> ERROR.
- CNT_HI: latch count[15:8] -> CNT_LO.
- CNT_LO: latch count[7:0], then:
  - count==0 -> IDLE; no writes.
  - count*4 > MEM_BYTES -> ERROR; no writes.
  - Otherwise -> DATA, with word address pointer = 0 and byte index = 0.
- DATA: bytes are shifted into a 32-bit assembly register.
  - On the edge accepting byte index 3: the next cycle shows mem_we=1 for exactly one cycle, with mem_wdata = assembled word and mem_addr = 4*word_index.
  - words_loaded increments on that same edge; it saturates at 0xFFFF.
  - After the last word, state -> IDLE on the same edge that accepts its 4th byte.
  - in_ready stays 1 throughout DATA, so back-to-back bytes are legal and the write cycle overlaps reception of the next word.
- Each frame restarts at address 0. A later frame to the same target overwrites earlier contents.
- DONE: cpu_hold=0 from the cycle after the 'G' byte is accepted. in_ready=0. All further input is ignored until reset.
- ERROR: err=1, in_ready=0, cpu_hold stays 1. The state persists until reset.
- Gaps: in_valid low simply stalls; there is no timeout.
- mem_addr, mem_sel and mem_wdata are registered. They hold their values when mem_we=0.
- Simultaneous events: reset has priority over any byte accepted on the same edge.

Test Plan:
- Reset, then stream 49 00 02 | 12 34 56 78 | 9A BC DE F0 -> two mem_we pulses, sel=0:
  - first: addr=0x000, wdata=0x12345678.
  - second: addr=0x004, wdata=0x9ABCDEF0.
  - words_loaded=2, cpu_hold=1, state back to IDLE.
- Stream 44 00 01 | 00 00 00 2A, then 47 -> one write with sel=1, addr=0, wdata=0x0000002A; cpu_hold falls the cycle after 47 is accepted; in_ready=0 thereafter; a further 49 produces no write.
- Stream 44 01 01 (257 words > 256 with MEM_BYTES=1024) -> err=1, in_ready=0, no mem_we pulse, cpu_hold=1.
- Stream 49 00 00 then 58 -> no writes after the zero-count frame; 0x58 drives ERROR with err=1.
- Stream 49 00 01 AA BB, then assert reset for 1 cycle, then stream 49 00 01 11 22 33 44 -> no write of a partial word; a single write of 0x11223344 at addr 0; words_loaded=1.
- Bytes with in_valid toggling every other cycle during DATA -> same write contents and addresses as the back-to-back case; mem_we is never high for 2 consecutive cycles.
